// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A winner holds the port for up to BURST_LEN beats or until its last beat.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 8,
    parameter int IDW        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            ack_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_o,
    output logic [IDW-1:0]                grant_id_o,
    output logic                          busy_o
);

    localparam int BCW = $clog2(BURST_LEN) + 1;

    typedef enum logic {
        ARB,
        BURST
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [IDW-1:0]   last_ptr_q, last_ptr_d;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
    logic             busy_q, busy_d;

    logic             sel_found;
    logic [IDW-1:0]   sel_idx;
    int               idx;
    logic             owner_req;
    logic             owner_ack;
    logic             burst_end;

    // Scan from the farthest offset down so the nearest requester after last_ptr wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(last_ptr_q) + off) % NUM_REQ;
            if (req_i[idx]) begin
                sel_found = 1'b1;
                sel_idx   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_ptr_d = last_ptr_q;
        beat_cnt_d = beat_cnt_q;
        busy_d     = busy_q;
        ack_o      = '0;
        owner_req  = req_i[grant_q];
        owner_ack  = 1'b0;
        burst_end  = req_last_i[grant_q] || (beat_cnt_q == BCW'(BURST_LEN - 1));

        case (state_q)
            ARB: begin
                if (sel_found) begin
                    grant_d    = sel_idx;
                    last_ptr_d = sel_idx;
                    beat_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = BURST;
                end
            end
            BURST: begin
                owner_ack      = owner_req && !fifo_full_i;
                ack_o[grant_q] = owner_ack;
                // A full FIFO freezes everything; only an accepted beat or a dropped req moves on.
                if (owner_ack) begin
                    if (burst_end) begin
                        state_d    = ARB;
                        busy_d     = 1'b0;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end else if (!owner_req) begin
                    state_d    = ARB;
                    busy_d     = 1'b0;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                state_d = ARB;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            grant_q    <= '0;
            last_ptr_q <= IDW'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_ptr_q <= last_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign fifo_wr_en_o = |ack_o;
    assign fifo_data_o  = req_data_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign grant_id_o   = grant_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: four requesters, 8-beat bursts,
// expected ack/grant/busy/data values written out cycle by cycle.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  reqBus = '0;
    logic [3:0]  reqLast = '0;
    logic [63:0] reqData = '0;
    logic        fifoFull = 1'b0;
    logic [3:0]  ack;
    logic        fifoWrEn;
    logic [15:0] fifoData;
    logic [1:0]  grantId;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int writes = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ(4),
        .DATA_WIDTH(16),
        .BURST_LEN(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_i(reqBus),
        .req_last_i(reqLast),
        .req_data_i(reqData),
        .ack_o(ack),
        .fifo_full_i(fifoFull),
        .fifo_wr_en_o(fifoWrEn),
        .fifo_data_o(fifoData),
        .grant_id_o(grantId),
        .busy_o(busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 2 time units after the edge; outputs settle by the return.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic f,
                                 input int dIdx, input logic [15:0] dVal);
        @(posedge clk);
        #2;
        reqBus   = r;
        reqLast  = l;
        fifoFull = f;
        reqData[dIdx*16 +: 16] = dVal;
        #1;
    endtask

    task automatic expectCycle(input string tag, input logic [3:0] ackExp, input logic [1:0] grantExp,
                               input logic busyExp, input logic [15:0] dataExp, input bit checkData);
        checkOutput({tag, " ack"}, 32'(ack), 32'(ackExp));
        checkOutput({tag, " wr_en"}, 32'(fifoWrEn), 32'(|ackExp));
        checkOutput({tag, " grant"}, 32'(grantId), 32'(grantExp));
        checkOutput({tag, " busy"}, 32'(busy), 32'(busyExp));
        if (checkData) checkOutput({tag, " data"}, 32'(fifoData), 32'(dataExp));
    endtask

    task automatic resetDut();
        reqBus   = '0;
        reqLast  = '0;
        fifoFull = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        expectCycle("reset", 4'b0000, 2'd0, 1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        int owner;
        $display("[TB] start");

        // Single requester, 8 beats with last on the eighth.
        resetDut();
        applyStimulus(4'b0100, 4'b0000, 1'b0, 2, 16'h0A00);
        expectCycle("t1 arb", 4'b0000, 2'd0, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b0100, (k == 7) ? 4'b0100 : 4'b0000, 1'b0, 2, 16'h0A00 + 16'(k));
            expectCycle("t1 beat", 4'b0100, 2'd2, 1'b1, 16'h0A00 + 16'(k), 1'b1);
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0, 2, 16'h0000);
        expectCycle("t1 done", 4'b0000, 2'd2, 1'b0, 16'h0, 1'b0);

        // All requesters active with 3-beat packets: strict rotation 0,1,2,3.
        resetDut();
        writes = 0;
        for (int b = 0; b < 8; b++) begin
            owner = b % 4;
            applyStimulus(4'b1111, 4'b0000, 1'b0, owner, {4'(owner), 4'(b), 8'h00});
            expectCycle("t2 arb", 4'b0000, (b == 0) ? 2'd0 : 2'((b - 1) % 4), 1'b0, 16'h0, 1'b0);
            for (int j = 0; j < 3; j++) begin
                applyStimulus(4'b1111, (j == 2) ? (4'b0001 << owner) : 4'b0000, 1'b0, owner,
                              {4'(owner), 4'(b), 8'(j)});
                expectCycle("t2 beat", 4'b0001 << owner, 2'(owner), 1'b1, {4'(owner), 4'(b), 8'(j)}, 1'b1);
                writes += int'(fifoWrEn);
            end
        end
        checkOutput("t2 writes", 32'(writes), 32'd24);

        // Requester 1 streams 20 beats without last; requester 3 waits its turn.
        resetDut();
        applyStimulus(4'b1010, 4'b0000, 1'b0, 1, 16'h1100);
        expectCycle("t3 arb0", 4'b0000, 2'd0, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1010, 4'b0000, 1'b0, 1, 16'h1100 + 16'(k));
            expectCycle("t3 r1a", 4'b0010, 2'd1, 1'b1, 16'h1100 + 16'(k), 1'b1);
        end
        applyStimulus(4'b1010, 4'b0000, 1'b0, 1, 16'h1108);
        expectCycle("t3 arb1", 4'b0000, 2'd1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(4'b1010, (k == 1) ? 4'b1000 : 4'b0000, 1'b0, 3, 16'h3300 + 16'(k));
            expectCycle("t3 r3", 4'b1000, 2'd3, 1'b1, 16'h3300 + 16'(k), 1'b1);
        end
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1, 16'h1108);
        expectCycle("t3 arb2", 4'b0000, 2'd3, 1'b0, 16'h0, 1'b0);
        for (int k = 8; k < 16; k++) begin
            applyStimulus(4'b0010, 4'b0000, 1'b0, 1, 16'h1100 + 16'(k));
            expectCycle("t3 r1b", 4'b0010, 2'd1, 1'b1, 16'h1100 + 16'(k), 1'b1);
        end
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1, 16'h1110);
        expectCycle("t3 arb3", 4'b0000, 2'd1, 1'b0, 16'h0, 1'b0);
        for (int k = 16; k < 20; k++) begin
            applyStimulus(4'b0010, (k == 19) ? 4'b0010 : 4'b0000, 1'b0, 1, 16'h1100 + 16'(k));
            expectCycle("t3 r1c", 4'b0010, 2'd1, 1'b1, 16'h1100 + 16'(k), 1'b1);
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1, 16'h0000);
        expectCycle("t3 done", 4'b0000, 2'd1, 1'b0, 16'h0, 1'b0);

        // FIFO full for 5 cycles after beat 3; beat count must stay frozen.
        resetDut();
        applyStimulus(4'b0001, 4'b0000, 1'b0, 0, 16'h4400);
        expectCycle("t4 arb", 4'b0000, 2'd0, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0001, 4'b0000, 1'b0, 0, 16'h4400 + 16'(k));
            expectCycle("t4 pre", 4'b0001, 2'd0, 1'b1, 16'h4400 + 16'(k), 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b0001, 4'b0000, 1'b1, 0, 16'h4403);
            expectCycle("t4 full", 4'b0000, 2'd0, 1'b1, 16'h4403, 1'b1);
        end
        for (int k = 3; k < 8; k++) begin
            applyStimulus(4'b0001, 4'b0000, 1'b0, 0, 16'h4400 + 16'(k));
            expectCycle("t4 post", 4'b0001, 2'd0, 1'b1, 16'h4400 + 16'(k), 1'b1);
        end
        applyStimulus(4'b0001, 4'b0000, 1'b0, 0, 16'h4408);
        expectCycle("t4 release", 4'b0000, 2'd0, 1'b0, 16'h0, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 0, 16'h0000);
        expectCycle("t4 regrant", 4'b0000, 2'd0, 1'b1, 16'h0, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 0, 16'h0000);
        expectCycle("t4 idle", 4'b0000, 2'd0, 1'b0, 16'h0, 1'b0);

        // Owner drops req after 2 beats; next owner gets a full 8-beat burst.
        resetDut();
        applyStimulus(4'b0101, 4'b0000, 1'b0, 0, 16'h5500);
        expectCycle("t5 arb", 4'b0000, 2'd0, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(4'b0101, 4'b0000, 1'b0, 0, 16'h5500 + 16'(k));
            expectCycle("t5 r0", 4'b0001, 2'd0, 1'b1, 16'h5500 + 16'(k), 1'b1);
        end
        applyStimulus(4'b0100, 4'b0000, 1'b0, 2, 16'h5600);
        expectCycle("t5 drop", 4'b0000, 2'd0, 1'b1, 16'h0, 1'b0);
        applyStimulus(4'b0100, 4'b0000, 1'b0, 2, 16'h5600);
        expectCycle("t5 arb2", 4'b0000, 2'd0, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b0100, 4'b0000, 1'b0, 2, 16'h5600 + 16'(k));
            expectCycle("t5 r2", 4'b0100, 2'd2, 1'b1, 16'h5600 + 16'(k), 1'b1);
        end
        applyStimulus(4'b0100, 4'b0000, 1'b0, 2, 16'h5608);
        expectCycle("t5 release", 4'b0000, 2'd2, 1'b0, 16'h0, 1'b0);

        // Asynchronous reset mid-burst, then restart from index 0.
        resetDut();
        applyStimulus(4'b0110, 4'b0000, 1'b0, 1, 16'h6600);
        expectCycle("t6 arb", 4'b0000, 2'd0, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(4'b0110, 4'b0000, 1'b0, 1, 16'h6600 + 16'(k));
            expectCycle("t6 r1", 4'b0010, 2'd1, 1'b1, 16'h6600 + 16'(k), 1'b1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        expectCycle("t6 in reset", 4'b0000, 2'd0, 1'b0, 16'h0, 1'b0);
        #2;
        rst_n = 1'b1;
        applyStimulus(4'b0110, 4'b0000, 1'b0, 1, 16'h6600);
        expectCycle("t6 regrant", 4'b0010, 2'd1, 1'b1, 16'h6600, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
